pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter/next-PC stage that consumes the branch-target LUT.
- Drives the LUT index from the decoded branch field.
- Loads the returned 7-bit absolute target on a taken branch; otherwise sequences the PC.
- Owns the run/halt state machine that starts, halts and restarts the program.

Parameters:
PC_W, 7, PC width; must match LUT output width
IDX_W, 6, LUT index width
START_PC, 0, PC loaded on start
PC_LAST, 127, highest legal PC; incrementing past it is out-of-bounds

Ports:
clk  in  1  system clock
rst_n  in  1  reset
start  in  1  one-cycle pulse; (re)starts execution at START_PC
stall  in  1  hold PC this cycle (RUN only)
halt  in  1  current instruction is halt
branch_en  in  1  current instruction is a branch
branch_cond  in  1  branch condition flag
branch_idx  in  IDX_W  LUT index field of the current instruction
lut_target  in  PC_W  target PC returned by the LUT
lut_index  out  IDX_W  index to the LUT
pc  out  PC_W  current program counter
running  out  1  high in RUN
done  out  1  sticky; set on halt or out-of-bounds, cleared by start
pc_oob  out  1  sticky; set when the PC ran past PC_LAST, cleared by start
instr_count  out  16  retired-instruction count (optional feature)
taken_count  out  16  taken-branch count (optional feature)

Behaviour:
- Reset:
  - Single clock clk; rst_n is asynchronous, active-low.
  - On reset: state=IDLE, pc=0, done=0, pc_oob=0, counters=0.
- Combinational paths:
  - lut_index = branch_idx at all times.
  - lut_target is consumed in the same cycle.
  - running = (state==RUN).
- States IDLE, RUN, HALT. All updates occur on the clk rising edge.
- IDLE:
  - start -> RUN, pc<=START_PC.
  - All other inputs are ignored.
- RUN priority (highest first):
  1. start: pc<=START_PC; clear done and pc_oob; stay RUN.
  2. halt: -> HALT, done<=1, pc holds. halt wins over stall and branch.
  3. stall: pc holds. Branch and halt are re-evaluated next cycle; no counter increments.
  4. branch_en & branch_cond: pc<=lut_target (absolute, no offset).
  5. Otherwise pc<=pc+1.
- Out-of-bounds: if pc==PC_LAST on the sequential path:
  - -> HALT, done<=1, pc_oob<=1, pc holds at PC_LAST (no wrap to 0).
  - A taken branch from PC_LAST is legal and follows the target.
- lut_target above PC_LAST is loaded unchanged. It trips pc_oob on its next sequential step only via the rule above.
- HALT:
  - pc and done hold.
  - start -> RUN, pc<=START_PC, clear done and pc_oob.
- branch_en with branch_cond=0 is treated as a not-taken branch (pc+1).
- Latency: new PC is visible one cycle after the deciding edge. No bubble on taken branches.
- rst_n asserted mid-RUN forces IDLE immediately (asynchronously); start is needed again to resume.

Optional Feature:
- Macro: PC_FETCH_STATS_EN.
- Defined:
  - instr_count increments on every non-stalled RUN cycle, halt cycle included.
  - taken_count increments on each taken branch.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset and on start.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package pc_fetch_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t
  - localparams PC_W_DEF=7, IDX_W_DEF=6
  - typedef logic [PC_W_DEF-1:0] pc_t
- Optional sub-module sat_counter16 (enable, clear, saturating), instantiated twice under PC_FETCH_STATS_EN.
- Otherwise the FSM and PC logic stay in one module.

Test Plan:
- Reset then start; no branches for 5 cycles -> pc 0,1,2,3,4,5; running=1; done=0.
- At pc=10: branch_en=1, branch_cond=1, branch_idx=3, LUT returns 30 -> lut_index=3; pc=30 next cycle. With branch_cond=0 -> pc=11.
- At pc=20: halt=1 and branch taken in the same cycle -> HALT; pc stays 20; done=1. Later start -> pc=0; done=0; running=1.
- Stall 3 cycles at pc=7 with a branch pending -> pc holds 7; counters frozen. Release -> branch taken to the LUT target.
- Run sequentially to pc=127 (PC_LAST) -> next cycle HALT, pc=127, pc_oob=1, done=1. Start clears both.
- With PC_FETCH_STATS_EN, 4 instructions including 1 taken branch then halt -> instr_count=5, taken_count=1. rst_n low mid-RUN -> immediate IDLE, pc=0, counts=0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the program-counter fetch controller.
package pc_fetch_pkg;

  localparam int unsigned PC_W_DEF  = 7;
  localparam int unsigned IDX_W_DEF = 6;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef logic [PC_W_DEF-1:0] pc_t;

endpackage

// File: rtl/pc_fetch_ctrl_sat_counter16.sv
// 16-bit saturating event counter with synchronous clear.
// Only built when PC_FETCH_STATS_EN is defined.
`ifdef PC_FETCH_STATS_EN
module sat_counter16
  import pc_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Clear beats increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/pc_fetch_ctrl.sv
// Next-PC stage with IDLE/RUN/HALT control, feeding and consuming the branch-target LUT.
// Optional retired/taken statistics counters are enabled with PC_FETCH_STATS_EN.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned START_PC = 0,
  parameter int unsigned PC_LAST  = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             branch_cond,
  input  logic [IDX_W-1:0] branch_idx,
  input  logic [PC_W-1:0]  lut_target,
  output logic [IDX_W-1:0] lut_index,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic             pc_oob,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] taken_count
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_pc_oob;
  logic            w_pc_oob_nxt;
  logic            w_retire;
  logic            w_taken;
  logic            w_clr;
  logic            w_br_taken;
  logic            w_at_last;

  assign w_br_taken = branch_en & branch_cond;
  assign w_at_last  = (r_pc == PC_W'(PC_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: start dominates, then halt, stall, taken branch, end-of-memory.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        if (start)                          w_state_nxt = RUN;
        else if (halt)                      w_state_nxt = HALT;
        else if (stall)                     w_state_nxt = RUN;
        else if (!w_br_taken && w_at_last)  w_state_nxt = HALT;
      end
      HALT: begin
        if (start) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath updates and counter strobes for the current cycle.
  always_comb begin
    w_pc_nxt     = r_pc;
    w_done_nxt   = r_done;
    w_pc_oob_nxt = r_pc_oob;
    w_retire     = 1'b0;
    w_taken      = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        if (start) begin
          w_pc_nxt     = PC_W'(START_PC);
          w_done_nxt   = 1'b0;
          w_pc_oob_nxt = 1'b0;
          w_clr        = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          w_pc_nxt     = PC_W'(START_PC);
          w_done_nxt   = 1'b0;
          w_pc_oob_nxt = 1'b0;
          w_clr        = 1'b1;
        end else if (halt) begin
          w_done_nxt = 1'b1;
          w_retire   = 1'b1;
        end else if (!stall) begin
          w_retire = 1'b1;
          if (w_br_taken) begin
            // Absolute target, loaded as-is even if beyond PC_LAST.
            w_pc_nxt = lut_target;
            w_taken  = 1'b1;
          end else if (w_at_last) begin
            w_done_nxt   = 1'b1;
            w_pc_oob_nxt = 1'b1;
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
      end
      default: begin
        w_pc_nxt = r_pc;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_done   <= 1'b0;
      r_pc_oob <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_done   <= w_done_nxt;
      r_pc_oob <= w_pc_oob_nxt;
    end
  end

  assign lut_index = branch_idx;
  assign running   = (r_state == RUN);
  assign pc        = r_pc;
  assign done      = r_done;
  assign pc_oob    = r_pc_oob;

`ifdef PC_FETCH_STATS_EN
  sat_counter16 u_instr_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_retire),
    .o_count (instr_count)
  );

  sat_counter16 u_taken_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_taken),
    .o_count (taken_count)
  );
`else
  logic w_unused_stats;
  assign w_unused_stats = ^{w_retire, w_taken, w_clr};
  assign instr_count    = '0;
  assign taken_count    = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized run
// against a cycle-level reference model. Honors PC_FETCH_STATS_EN for counter checks.
module tb_pc_fetch_ctrl;
  import pc_fetch_pkg::*;

  localparam int unsigned PC_W  = 7;
  localparam int unsigned IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             stall;
  logic             halt;
  logic             branch_en;
  logic             branch_cond;
  logic [IDX_W-1:0] branch_idx;
  logic [PC_W-1:0]  lut_target;
  logic [IDX_W-1:0] lut_index;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;
  logic             pc_oob;
  logic [15:0]      instr_count;
  logic [15:0]      taken_count;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=idle 1=run 2=halted
  int m_mode;
  int m_pc;
  bit m_done;
  bit m_oob;
  int m_ic;
  int m_tc;

  pc_fetch_ctrl #(
    .PC_W(PC_W), .IDX_W(IDX_W), .START_PC(0), .PC_LAST(127)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_cond(branch_cond), .branch_idx(branch_idx),
    .lut_target(lut_target), .lut_index(lut_index), .pc(pc), .running(running),
    .done(done), .pc_oob(pc_oob), .instr_count(instr_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int exp_cnt(input int v);
`ifdef PC_FETCH_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_done = 0; m_oob = 0; m_ic = 0; m_tc = 0;
  endtask

  task automatic model_restart();
    m_mode = 1; m_pc = 0; m_done = 0; m_oob = 0; m_ic = 0; m_tc = 0;
  endtask

  // Applies the behaviour rules for one rising edge with the current inputs.
  task automatic model_edge();
    if (m_mode == 0) begin
      if (start) model_restart();
    end else if (m_mode == 2) begin
      if (start) model_restart();
    end else begin
      if (start) model_restart();
      else if (halt) begin
        m_mode = 2; m_done = 1; m_ic = sat16(m_ic + 1);
      end else if (!stall) begin
        m_ic = sat16(m_ic + 1);
        if (branch_en && branch_cond) begin
          m_pc = int'(lut_target); m_tc = sat16(m_tc + 1);
        end else if (m_pc == 127) begin
          m_mode = 2; m_done = 1; m_oob = 1;
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; halt = 0; branch_en = 0; branch_cond = 0;
    branch_idx = '0; lut_target = '0;
  endtask

  // Restart and walk sequentially to the requested PC.
  task automatic goto_pc(input int target);
    clear_inputs();
    start = 1; step(); start = 0;
    for (int i = 0; i < 200 && m_pc != target; i++) step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    #12;
    tests++;
    if (pc !== 7'd0 || running !== 1'b0 || done !== 1'b0 || pc_oob !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: pc=%0d run=%b done=%b oob=%b want 0/0/0/0", pc, running, done, pc_oob);
    end
    tests++;
    if (instr_count !== 16'd0 || taken_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_counts: ic=%0d tc=%0d want 0/0", instr_count, taken_count);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    // Inputs other than start are ignored in IDLE
    halt = 1; branch_en = 1; branch_cond = 1; lut_target = 7'd99;
    step(); step();
    clear_inputs();
    tests++;
    if (pc !== 7'd0 || running !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: pc=%0d run=%b want 0/0", pc, running);
    end
  endtask

  task automatic test_sequential();
    clear_inputs();
    start = 1; step(); start = 0;
    for (int k = 0; k <= 5; k++) begin
      tests++;
      if (pc !== 7'(k) || running !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL seq_pc step %0d: pc=%0d run=%b done=%b want %0d/1/0", k, pc, running, done, k);
      end
      if (k < 5) step();
    end
  endtask

  task automatic test_branch();
    goto_pc(10);
    branch_en = 1; branch_cond = 1; branch_idx = 6'd3; lut_target = 7'd30;
    #1;
    tests++;
    if (lut_index !== 6'd3) begin
      fails++;
      $display("FAIL lut_index: got %0d want 3", lut_index);
    end
    step();
    tests++;
    if (pc !== 7'd30) begin
      fails++;
      $display("FAIL branch_taken: pc=%0d want 30", pc);
    end
    goto_pc(10);
    branch_en = 1; branch_cond = 0; branch_idx = 6'd3; lut_target = 7'd30;
    step();
    clear_inputs();
    tests++;
    if (pc !== 7'd11) begin
      fails++;
      $display("FAIL branch_not_taken: pc=%0d want 11", pc);
    end
  endtask

  task automatic test_halt();
    goto_pc(20);
    halt = 1; branch_en = 1; branch_cond = 1; lut_target = 7'd50;
    step();
    clear_inputs();
    step(); step();
    tests++;
    if (pc !== 7'd20 || done !== 1'b1 || running !== 1'b0) begin
      fails++;
      $display("FAIL halt_hold: pc=%0d done=%b run=%b want 20/1/0", pc, done, running);
    end
    start = 1; step(); start = 0;
    tests++;
    if (pc !== 7'd0 || done !== 1'b0 || running !== 1'b1) begin
      fails++;
      $display("FAIL halt_restart: pc=%0d done=%b run=%b want 0/0/1", pc, done, running);
    end
  endtask

  task automatic test_stall();
    int ic0;
    goto_pc(7);
    ic0 = exp_cnt(7);
    stall = 1; branch_en = 1; branch_cond = 1; lut_target = 7'd40; branch_idx = 6'd9;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if (pc !== 7'd7 || instr_count !== 16'(ic0) || taken_count !== 16'd0) begin
        fails++;
        $display("FAIL stall_hold cyc %0d: pc=%0d ic=%0d tc=%0d want 7/%0d/0", k, pc, instr_count, taken_count, ic0);
      end
    end
    stall = 0;
    step();
    clear_inputs();
    tests++;
    if (pc !== 7'd40 || taken_count !== 16'(exp_cnt(1))) begin
      fails++;
      $display("FAIL stall_release: pc=%0d tc=%0d want 40/%0d", pc, taken_count, exp_cnt(1));
    end
  endtask

  task automatic test_oob();
    goto_pc(127);
    tests++;
    if (pc !== 7'd127 || running !== 1'b1) begin
      fails++;
      $display("FAIL oob_reach: pc=%0d run=%b want 127/1", pc, running);
    end
    step();
    tests++;
    if (pc !== 7'd127 || pc_oob !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin
      fails++;
      $display("FAIL oob_trip: pc=%0d oob=%b done=%b run=%b want 127/1/1/0", pc, pc_oob, done, running);
    end
    start = 1; step(); start = 0;
    tests++;
    if (pc_oob !== 1'b0 || done !== 1'b0 || pc !== 7'd0) begin
      fails++;
      $display("FAIL oob_clear: oob=%b done=%b pc=%0d want 0/0/0", pc_oob, done, pc);
    end
    goto_pc(127);
    branch_en = 1; branch_cond = 1; lut_target = 7'd5;
    step();
    clear_inputs();
    tests++;
    if (pc !== 7'd5 || pc_oob !== 1'b0 || running !== 1'b1) begin
      fails++;
      $display("FAIL oob_branch: pc=%0d oob=%b run=%b want 5/0/1", pc, pc_oob, running);
    end
  endtask

  task automatic test_stats();
    clear_inputs();
    start = 1; step(); start = 0;
    step(); step();
    branch_en = 1; branch_cond = 1; lut_target = 7'd60;
    step();
    clear_inputs();
    step();
    halt = 1; step(); halt = 0;
    tests++;
    if (instr_count !== 16'(exp_cnt(5)) || taken_count !== 16'(exp_cnt(1))) begin
      fails++;
      $display("FAIL stats_counts: ic=%0d tc=%0d want %0d/%0d", instr_count, taken_count, exp_cnt(5), exp_cnt(1));
    end
    tests++;
    if (pc !== 7'd61 || done !== 1'b1) begin
      fails++;
      $display("FAIL stats_halt_pc: pc=%0d done=%b want 61/1", pc, done);
    end
  endtask

  task automatic test_reset_midrun();
    clear_inputs();
    start = 1; step(); start = 0;
    step(); step(); step();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    tests++;
    if (running !== 1'b0 || pc !== 7'd0 || instr_count !== 16'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: run=%b pc=%0d ic=%0d done=%b want 0/0/0/0", running, pc, instr_count, done);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    step(); step();
    tests++;
    if (running !== 1'b0 || pc !== 7'd0) begin
      fails++;
      $display("FAIL reset_stay_idle: run=%b pc=%0d want 0/0", running, pc);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      start       = ($urandom_range(99) < 4);
      halt        = ($urandom_range(99) < 3);
      stall       = ($urandom_range(99) < 20);
      branch_en   = ($urandom_range(99) < 30);
      branch_cond = $urandom_range(1);
      branch_idx  = IDX_W'($urandom);
      lut_target  = PC_W'($urandom);
      #1;
      tests++;
      if (lut_index !== branch_idx) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL rand_lut_index cyc %0d: got %0d want %0d", c, lut_index, branch_idx);
      end
      step();
      tests++;
      if (pc !== 7'(m_pc) || done !== m_done || pc_oob !== m_oob || running !== (m_mode == 1) ||
          instr_count !== 16'(exp_cnt(m_ic)) || taken_count !== 16'(exp_cnt(m_tc))) begin
        fails++; errs++;
        if (errs < 10)
          $display("FAIL rand_state cyc %0d: pc=%0d done=%b oob=%b run=%b ic=%0d tc=%0d want %0d/%0d/%0d/%0d/%0d/%0d",
                   c, pc, done, pc_oob, running, instr_count, taken_count,
                   m_pc, m_done, m_oob, (m_mode == 1), exp_cnt(m_ic), exp_cnt(m_tc));
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_stall();
    test_oob();
    test_stats();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
